packet: RTL and testbench

Packet-level arbiter for the four TX AXI-S request ports (CFG, CC, RW, RR) in `axi_enhanced_tx`. It drives `channel_sel` and the per-port throttle flags into the TX port mux, and holds a grant from a port's first accepted beat through its `tlast` beat. CFG has strict priority. CC, RW and RR share the remaining bandwidth round-robin, gated by per-port credit-available flags.

---
 rtl/packet_if.sv | 63 ++++++
 rtl/packet.sv | 199 +++++++++++++++++++
 tb/tb_packet.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_if.sv
`default_nettype none
// ============================================================================
// Module      : packet_if
// Description : TX arbiter handshake bundle. Carries the four request-port
//               AXI-S handshakes, the pipeline TREADY, credit and link
//               status into the arbiter, and channel select / throttle /
//               busy status back out to the TX port mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface packet_if;
    // Request-port handshakes (tready is produced by the TX port mux)
    logic       s_axis_cfg_tvalid;
    logic       s_axis_cfg_tlast;
    logic       s_axis_cfg_tready;
    logic       s_axis_cc_tvalid;
    logic       s_axis_cc_tlast;
    logic       s_axis_cc_tready;
    logic       s_axis_rw_tvalid;
    logic       s_axis_rw_tlast;
    logic       s_axis_rw_tready;
    logic       s_axis_rr_tvalid;
    logic       s_axis_rr_tlast;
    logic       s_axis_rr_tready;

    // Pipeline readiness, link and credit status
    logic       s_axis_tx_tready;
    logic       trn_lnk_up;
    logic       cc_credit_ok;
    logic       rw_credit_ok;
    logic       rr_credit_ok;

    // Arbiter decisions towards the TX port mux
    logic [1:0] channel_sel;
    logic       cc_thrtl;
    logic       rw_thrtl;
    logic       rr_thrtl;
    logic       arb_busy;

    // Arbiter side
    modport slave (
        input  s_axis_cfg_tvalid, s_axis_cfg_tlast, s_axis_cfg_tready,
        input  s_axis_cc_tvalid,  s_axis_cc_tlast,  s_axis_cc_tready,
        input  s_axis_rw_tvalid,  s_axis_rw_tlast,  s_axis_rw_tready,
        input  s_axis_rr_tvalid,  s_axis_rr_tlast,  s_axis_rr_tready,
        input  s_axis_tx_tready,  trn_lnk_up,
        input  cc_credit_ok,      rw_credit_ok,     rr_credit_ok,
        output channel_sel,       cc_thrtl,         rw_thrtl,
        output rr_thrtl,          arb_busy
    );

    // Traffic / mux side
    modport master (
        output s_axis_cfg_tvalid, s_axis_cfg_tlast, s_axis_cfg_tready,
        output s_axis_cc_tvalid,  s_axis_cc_tlast,  s_axis_cc_tready,
        output s_axis_rw_tvalid,  s_axis_rw_tlast,  s_axis_rw_tready,
        output s_axis_rr_tvalid,  s_axis_rr_tlast,  s_axis_rr_tready,
        output s_axis_tx_tready,  trn_lnk_up,
        output cc_credit_ok,      rw_credit_ok,     rr_credit_ok,
        input  channel_sel,       cc_thrtl,         rw_thrtl,
        input  rr_thrtl,          arb_busy
    );
endinterface
`default_nettype wire

// File: rtl/packet.sv
`default_nettype none
// ============================================================================
// Module      : packet
// Description : Packet-level TX arbiter. CFG has strict priority and is
//               parked on the mux while idle; CC, RW and RR share the
//               remaining bandwidth round-robin, gated by credit and link.
//               A grant is held from the first accepted beat to tlast.
// Revision    : 1.0 - initial release
// ============================================================================
module packet (
    input  wire logic com_iclk,
    input  wire logic com_sysrst,
    packet_if.slave   arb
);

    // Channel select encodings, also used as round-robin pointer values
    localparam logic [1:0] c_sel_cfg = 2'b00;
    localparam logic [1:0] c_sel_cc  = 2'b01;
    localparam logic [1:0] c_sel_rw  = 2'b10;
    localparam logic [1:0] c_sel_rr  = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_channel_sel;
    logic [1:0] w_channel_sel_nxt;
    logic [1:0] r_rr_ptr;
    logic [1:0] w_rr_ptr_nxt;
    logic       r_cc_thrtl;
    logic       r_rw_thrtl;
    logic       r_rr_thrtl;
    logic       w_cc_thrtl_nxt;
    logic       w_rw_thrtl_nxt;
    logic       w_rr_thrtl_nxt;

    logic       w_cfg_acc;
    logic       w_cc_acc;
    logic       w_rw_acc;
    logic       w_rr_acc;
    logic       w_cc_elig;
    logic       w_rw_elig;
    logic       w_rr_elig;
    logic       w_sel_acc;
    logic       w_sel_last;
    logic [1:0] w_rr_pick;
    logic       w_rr_found;
    logic [1:0] w_ptr_after;

    // Beat acceptance per port
    assign w_cfg_acc = arb.s_axis_cfg_tvalid && arb.s_axis_cfg_tready;
    assign w_cc_acc  = arb.s_axis_cc_tvalid  && arb.s_axis_cc_tready;
    assign w_rw_acc  = arb.s_axis_rw_tvalid  && arb.s_axis_rw_tready;
    assign w_rr_acc  = arb.s_axis_rr_tvalid  && arb.s_axis_rr_tready;

    // Credit and link only matter at the moment a grant is made
    assign w_cc_elig = arb.s_axis_cc_tvalid && arb.cc_credit_ok && arb.trn_lnk_up;
    assign w_rw_elig = arb.s_axis_rw_tvalid && arb.rw_credit_ok && arb.trn_lnk_up;
    assign w_rr_elig = arb.s_axis_rr_tvalid && arb.rr_credit_ok && arb.trn_lnk_up;

    // Acceptance and tlast of whichever port currently owns the mux
    always_comb begin
        w_sel_acc  = 1'b0;
        w_sel_last = 1'b0;
        case (r_channel_sel)
            c_sel_cc: begin
                w_sel_acc  = w_cc_acc;
                w_sel_last = arb.s_axis_cc_tlast;
            end
            c_sel_rw: begin
                w_sel_acc  = w_rw_acc;
                w_sel_last = arb.s_axis_rw_tlast;
            end
            c_sel_rr: begin
                w_sel_acc  = w_rr_acc;
                w_sel_last = arb.s_axis_rr_tlast;
            end
            default: begin
                w_sel_acc  = w_cfg_acc;
                w_sel_last = arb.s_axis_cfg_tlast;
            end
        endcase
    end

    // Cyclic search for the first eligible port starting at rr_ptr
    always_comb begin
        w_rr_found = 1'b1;
        w_rr_pick  = c_sel_cc;
        case (r_rr_ptr)
            c_sel_rw: begin
                if (w_rw_elig)      w_rr_pick = c_sel_rw;
                else if (w_rr_elig) w_rr_pick = c_sel_rr;
                else if (w_cc_elig) w_rr_pick = c_sel_cc;
                else                w_rr_found = 1'b0;
            end
            c_sel_rr: begin
                if (w_rr_elig)      w_rr_pick = c_sel_rr;
                else if (w_cc_elig) w_rr_pick = c_sel_cc;
                else if (w_rw_elig) w_rr_pick = c_sel_rw;
                else                w_rr_found = 1'b0;
            end
            default: begin
                if (w_cc_elig)      w_rr_pick = c_sel_cc;
                else if (w_rw_elig) w_rr_pick = c_sel_rw;
                else if (w_rr_elig) w_rr_pick = c_sel_rr;
                else                w_rr_found = 1'b0;
            end
        endcase
    end

    // Pointer value after serving the currently granted port (RR wraps to CC)
    always_comb begin
        case (r_channel_sel)
            c_sel_cc: w_ptr_after = c_sel_rw;
            c_sel_rw: w_ptr_after = c_sel_rr;
            default:  w_ptr_after = c_sel_cc;
        endcase
    end

    // Next-state and next-grant decision
    always_comb begin
        w_state_nxt       = r_state;
        w_channel_sel_nxt = r_channel_sel;
        w_rr_ptr_nxt      = r_rr_ptr;

        if (!arb.trn_lnk_up) begin
            // Link loss abandons any partial packet; the mux flushes it
            w_state_nxt       = IDLE;
            w_channel_sel_nxt = c_sel_cfg;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt       = IDLE;
                    w_channel_sel_nxt = c_sel_cfg;
                    if (w_cfg_acc) begin
                        // Multi-beat CFG keeps the mux; single-beat CFG is done
                        if (!arb.s_axis_cfg_tlast) begin
                            w_state_nxt = BUSY;
                        end
                    end else if (arb.s_axis_cfg_tvalid) begin
                        // CFG waiting on the pipeline keeps its priority
                        w_state_nxt = IDLE;
                    end else if (w_rr_found) begin
                        w_state_nxt       = BUSY;
                        w_channel_sel_nxt = w_rr_pick;
                    end
                end
                BUSY: begin
                    if (w_sel_acc && w_sel_last) begin
                        w_state_nxt       = IDLE;
                        w_channel_sel_nxt = c_sel_cfg;
                        if (r_channel_sel != c_sel_cfg) begin
                            w_rr_ptr_nxt = w_ptr_after;
                        end
                    end
                end
                default: begin
                    w_state_nxt       = IDLE;
                    w_channel_sel_nxt = c_sel_cfg;
                end
            endcase
        end
    end

    // Only the port holding a non-CFG grant is released from throttle
    assign w_cc_thrtl_nxt = !((w_state_nxt == BUSY) && (w_channel_sel_nxt == c_sel_cc));
    assign w_rw_thrtl_nxt = !((w_state_nxt == BUSY) && (w_channel_sel_nxt == c_sel_rw));
    assign w_rr_thrtl_nxt = !((w_state_nxt == BUSY) && (w_channel_sel_nxt == c_sel_rr));

    // State, grant and pointer registers
    always_ff @(posedge com_iclk) begin
        if (com_sysrst) begin
            r_state       <= IDLE;
            r_channel_sel <= c_sel_cfg;
            r_cc_thrtl    <= 1'b1;
            r_rw_thrtl    <= 1'b1;
            r_rr_thrtl    <= 1'b1;
            r_rr_ptr      <= c_sel_cc;
        end else begin
            r_state       <= w_state_nxt;
            r_channel_sel <= w_channel_sel_nxt;
            r_cc_thrtl    <= w_cc_thrtl_nxt;
            r_rw_thrtl    <= w_rw_thrtl_nxt;
            r_rr_thrtl    <= w_rr_thrtl_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
        end
    end

    assign arb.channel_sel = r_channel_sel;
    assign arb.cc_thrtl    = r_cc_thrtl;
    assign arb.rw_thrtl    = r_rw_thrtl;
    assign arb.rr_thrtl    = r_rr_thrtl;
    assign arb.arb_busy    = (r_state == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_packet.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet
// Description : Self-checking bench for the packet TX arbiter. Per-port
//               packet sources plus a mux model drive the DUT; a
//               grant-level reference model predicts the outputs each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    packet_if pif ();

    packet dut (
        .com_iclk   (clk),
        .com_sysrst (rst),
        .arb        (pif)
    );

    // Index 0 = CFG, 1 = CC, 2 = RW, 3 = RR
    logic [3:0] v    = 4'b0000;
    logic [3:0] lst  = 4'b0000;
    logic [3:0] cred = 4'b1111;
    logic       txr  = 1'b1;
    logic       lnk  = 1'b1;

    assign pif.s_axis_cfg_tvalid = v[0];
    assign pif.s_axis_cc_tvalid  = v[1];
    assign pif.s_axis_rw_tvalid  = v[2];
    assign pif.s_axis_rr_tvalid  = v[3];
    assign pif.s_axis_cfg_tlast  = lst[0];
    assign pif.s_axis_cc_tlast   = lst[1];
    assign pif.s_axis_rw_tlast   = lst[2];
    assign pif.s_axis_rr_tlast   = lst[3];
    assign pif.cc_credit_ok      = cred[1];
    assign pif.rw_credit_ok      = cred[2];
    assign pif.rr_credit_ok      = cred[3];
    assign pif.s_axis_tx_tready  = txr;
    assign pif.trn_lnk_up        = lnk;

    // TX port mux: a port is ready only when selected and not throttled
    assign pif.s_axis_cfg_tready = txr && (pif.channel_sel == 2'b00);
    assign pif.s_axis_cc_tready  = txr && (pif.channel_sel == 2'b01) && !pif.cc_thrtl;
    assign pif.s_axis_rw_tready  = txr && (pif.channel_sel == 2'b10) && !pif.rw_thrtl;
    assign pif.s_axis_rr_tready  = txr && (pif.channel_sel == 2'b11) && !pif.rr_thrtl;

    int checks = 0;
    int errors = 0;

    // Packet sources
    int src_len  [4];
    int src_beat [4];
    bit src_rep  [4];

    // Reference model: owner of the mux (-1 idle, else port index) and pointer
    int m_port = -1;
    int m_ptr  = 1;
    int nm_port;
    int nm_ptr;

    // Observation logs
    int grants[$];
    int pkt_beats[$];
    int beat_cnt  = 0;
    bit prev_busy = 1'b0;

    function automatic logic [5:0] got_vec();
        return {pif.channel_sel, pif.cc_thrtl, pif.rw_thrtl, pif.rr_thrtl, pif.arb_busy};
    endfunction

    function automatic logic [5:0] exp_vec();
        logic [1:0] s;
        if (m_port < 0) return 6'b00_111_0;
        s = m_port[1:0];
        return {s, (m_port != 1), (m_port != 2), (m_port != 3), 1'b1};
    endfunction

    task automatic refresh_last();
        for (int p = 0; p < 4; p++) lst[p] = (src_beat[p] == src_len[p] - 1);
    endtask

    task automatic start_pkt(input int p, input int len, input bit rep);
        src_len[p]  = len;
        src_beat[p] = 0;
        src_rep[p]  = rep;
        v[p]        = 1'b1;
        refresh_last();
    endtask

    task automatic clear_srcs();
        for (int p = 0; p < 4; p++) begin
            src_len[p] = 1; src_beat[p] = 0; src_rep[p] = 1'b0;
        end
        v = 4'b0000;
        refresh_last();
    endtask

    // Grant rules: reset/link override, CFG first, then cyclic credit search
    task automatic model_step();
        nm_port = m_port;
        nm_ptr  = m_ptr;
        if (rst) begin
            nm_port = -1;
            nm_ptr  = 1;
        end else if (!lnk) begin
            nm_port = -1;
        end else if (m_port < 0) begin
            if (v[0] && txr) begin
                nm_port = lst[0] ? -1 : 0;
            end else if (!v[0]) begin
                for (int k = 0; k < 3; k++) begin
                    int p;
                    p = ((m_ptr - 1 + k) % 3) + 1;
                    if (v[p] && cred[p]) begin
                        nm_port = p;
                        break;
                    end
                end
            end
        end else if (v[m_port] && txr && lst[m_port]) begin
            nm_port = -1;
            if (m_port != 0) nm_ptr = (m_port % 3) + 1;
        end
    endtask

    // One clock: predict, advance, then update sources from real handshakes
    task automatic tick();
        logic [3:0] acc;
        logic [1:0] s;
        #2;
        acc = {pif.s_axis_rr_tready & v[3], pif.s_axis_rw_tready & v[2],
               pif.s_axis_cc_tready & v[1], pif.s_axis_cfg_tready & v[0]};
        model_step();
        s = pif.channel_sel;
        if (acc[s]) begin
            beat_cnt++;
            if (lst[s]) begin
                pkt_beats.push_back(beat_cnt);
                beat_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        m_port = nm_port;
        m_ptr  = nm_ptr;
        for (int p = 0; p < 4; p++) begin
            if (acc[p]) begin
                if (lst[p]) begin
                    src_beat[p] = 0;
                    if (!src_rep[p]) v[p] = 1'b0;
                end else begin
                    src_beat[p]++;
                end
            end
        end
        refresh_last();
        if (pif.arb_busy && !prev_busy) grants.push_back(int'(pif.channel_sel));
        prev_busy = pif.arb_busy;
    endtask

    task automatic apply_reset();
        clear_srcs();
        cred = 4'b1111; txr = 1'b1; lnk = 1'b1;
        rst  = 1'b1;
        tick(); tick();
        rst  = 1'b0;
        grants.delete(); pkt_beats.delete(); beat_cnt = 0;
    endtask

    task automatic test_reset();
        clear_srcs();
        rst = 1'b1;
        tick();
        checks++;
        if (got_vec() !== 6'b00_111_0) begin
            errors++; $display("FAIL reset_values got=%b exp=%b", got_vec(), 6'b00_111_0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (got_vec() !== 6'b00_111_0) begin
                errors++; $display("FAIL reset_idle cyc%0d got=%b exp=%b", i, got_vec(), 6'b00_111_0);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_order[6] = '{1, 2, 3, 1, 2, 3};
        apply_reset();
        for (int p = 1; p < 4; p++) start_pkt(p, 3, 1'b1);
        for (int i = 0; i < 26; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL rr_cycle%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (grants.size() < 6) begin
            errors++; $display("FAIL rr_grant_count got=%0d exp>=6", grants.size());
        end else begin
            for (int g = 0; g < 6; g++) begin
                if (grants[g] !== exp_order[g]) begin
                    errors++; $display("FAIL rr_order%0d got=%0d exp=%0d", g, grants[g], exp_order[g]);
                end
            end
        end
        checks++;
        if (pkt_beats.size() < 5) begin
            errors++; $display("FAIL rr_pkt_count got=%0d exp>=5", pkt_beats.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
                if (pkt_beats[g] !== 3) begin
                    errors++; $display("FAIL rr_beats%0d got=%0d exp=3", g, pkt_beats[g]);
                end
            end
        end
    endtask

    task automatic test_cfg_preempt();
        int n = 0;
        apply_reset();
        start_pkt(2, 4, 1'b0);
        while (src_beat[2] != 2 && n < 20) begin
            tick(); n++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL cfg_pre_rw got=%b exp=%b", got_vec(), exp_vec());
            end
        end
        checks++;
        if (src_beat[2] != 2) begin
            errors++; $display("FAIL cfg_rw_timeout beat=%0d exp=2", src_beat[2]);
        end
        grants.delete();
        start_pkt(0, 4, 1'b0);
        start_pkt(1, 3, 1'b0);
        start_pkt(3, 3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL cfg_cycle%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (pkt_beats.size() < 2 || pkt_beats[0] !== 4 || pkt_beats[1] !== 4) begin
            errors++; $display("FAIL cfg_beats got_n=%0d exp rw=4 cfg=4", pkt_beats.size());
        end
        checks++;
        if (grants.size() < 2 || grants[0] !== 0 || grants[1] !== 3) begin
            errors++; $display("FAIL cfg_order got_n=%0d first=%0d exp CFG(0) then RR(3)",
                               grants.size(), (grants.size() > 0) ? grants[0] : -1);
        end
    endtask

    task automatic test_credit();
        for (int sub = 0; sub < 2; sub++) begin
            apply_reset();
            start_pkt(1, 1, 1'b0);
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (got_vec() !== exp_vec()) begin
                    errors++; $display("FAIL cred_warm%0d got=%b exp=%b", sub, got_vec(), exp_vec());
                end
            end
            grants.delete(); pkt_beats.delete(); beat_cnt = 0;
            cred[2] = 1'b0;
            start_pkt(1, 4, 1'b0);
            start_pkt(2, 2, 1'b0);
            if (sub == 0) start_pkt(3, 2, 1'b0);
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL cred_grant%0d got=%b exp=%b", sub, got_vec(), exp_vec());
            end
            if (sub == 1) cred[1] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                checks++;
                if (got_vec() !== exp_vec()) begin
                    errors++; $display("FAIL cred_cycle%0d_%0d got=%b exp=%b", sub, i, got_vec(), exp_vec());
                end
            end
            checks++;
            if (grants.size() < 1 || grants[0] !== ((sub == 0) ? 3 : 1)) begin
                errors++; $display("FAIL cred_skip%0d got=%0d exp=%0d", sub,
                                   (grants.size() > 0) ? grants[0] : -1, (sub == 0) ? 3 : 1);
            end
            if (sub == 1) begin
                checks++;
                if (pkt_beats.size() < 1 || pkt_beats[0] !== 4) begin
                    errors++; $display("FAIL cred_drop_mid got_n=%0d exp cc 4 beats", pkt_beats.size());
                end
            end
        end
    endtask

    task automatic test_link_down();
        int n = 0;
        apply_reset();
        start_pkt(1, 1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        start_pkt(3, 5, 1'b0);
        while (src_beat[3] != 2 && n < 20) begin
            tick(); n++;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL link_pre got=%b exp=%b", got_vec(), exp_vec());
            end
        end
        checks++;
        if (src_beat[3] != 2) begin
            errors++; $display("FAIL link_rr_timeout beat=%0d exp=2", src_beat[3]);
        end
        lnk = 1'b0;
        tick();
        checks++;
        if (got_vec() !== 6'b00_111_0) begin
            errors++; $display("FAIL link_drop got=%b exp=%b", got_vec(), 6'b00_111_0);
        end
        grants.delete();
        start_pkt(1, 2, 1'b0);
        start_pkt(2, 2, 1'b0);
        start_pkt(3, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL link_down%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (grants.size() != 0) begin
            errors++; $display("FAIL link_no_grant got=%0d exp=0", grants.size());
        end
        lnk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL link_up%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (grants.size() < 1 || grants[0] !== 2) begin
            errors++; $display("FAIL link_resume got=%0d exp=2", (grants.size() > 0) ? grants[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        apply_reset();
        start_pkt(1, 1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        start_pkt(1, 6, 1'b0);
        while (!pif.arb_busy && n < 10) begin
            tick(); n++;
        end
        for (int i = 0; i < 3; i++) begin
            txr = ~txr;
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL rstmid_busy%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (got_vec() !== 6'b00_111_0) begin
            errors++; $display("FAIL rstmid_values got=%b exp=%b", got_vec(), 6'b00_111_0);
        end
        clear_srcs();
        txr = 1'b1;
        grants.delete();
        start_pkt(1, 2, 1'b0);
        start_pkt(2, 2, 1'b0);
        start_pkt(3, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL rstmid_after%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (grants.size() < 1 || grants[0] !== 1) begin
            errors++; $display("FAIL rstmid_first_grant got=%0d exp=1", (grants.size() > 0) ? grants[0] : -1);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 4; p++) begin
                if (!v[p] && ($urandom % 4 == 0)) start_pkt(p, 1 + int'($urandom % 5), 1'b0);
            end
            cred = {($urandom % 4 != 0), ($urandom % 4 != 0), ($urandom % 4 != 0), 1'b1};
            txr  = ($urandom % 4 != 0);
            if ($urandom % 100 == 0) lnk = ~lnk;
            rst  = ($urandom % 250 == 0);
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL rand_cycle%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
        rst = 1'b0;
        lnk = 1'b1;
    endtask

    initial begin
        clear_srcs();
        test_reset();
        test_round_robin();
        test_cfg_preempt();
        test_credit();
        test_link_down();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
